// File: rtl/fir_line_buffer_pkg.sv
// Shared constants for the FIR line buffer: pixel width, tap count,
// and the helper that sizes the column counter.
package fir_line_buffer_pkg;

    localparam int PIX_W     = 8;
    localparam int FIR_TAPS  = 5;
    localparam int LINE_BUFS = FIR_TAPS - 1;

    // Never returns 0, so a 1-pixel-wide image still gets a legal vector.
    function automatic int col_w(input int img_width);
        return (img_width > 1) ? $clog2(img_width) : 1;
    endfunction

endpackage

// File: rtl/fir_line_buffer_if.sv
// Pixel-stream bundle between a raster source and the line buffer, plus the
// aligned 5-row column window it produces.
interface fir_line_buffer_if #(
    parameter int IMG_WIDTH = 640
);
    import fir_line_buffer_pkg::*;

    localparam int COL_W = col_w(IMG_WIDTH);

    // Handshake: valid-only, no ready. A beat transfers on every clock edge
    // where in_valid=1; in_sof is meaningful only on such a beat. out_valid
    // qualifies pixel0..4/out_col for exactly the cycle it is high.
    logic             in_valid;
    logic             in_sof;
    logic [PIX_W-1:0] in_pixel;
    logic [PIX_W-1:0] pixel0;
    logic [PIX_W-1:0] pixel1;
    logic [PIX_W-1:0] pixel2;
    logic [PIX_W-1:0] pixel3;
    logic [PIX_W-1:0] pixel4;
    logic [COL_W-1:0] out_col;
    logic             out_valid;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  pixel0, pixel1, pixel2, pixel3, pixel4, out_col, out_valid
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output pixel0, pixel1, pixel2, pixel3, pixel4, out_col, out_valid
    );

endinterface

// File: rtl/fir_line_buffer_line_ram.sv
// One stored image line: single-port, read-first. rdata shows the pre-write
// content of addr, so a read and a write to the same column share one cycle.
module fir_line_buffer_line_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/fir_line_buffer.sv
// Raster pixel stream to 5 vertically aligned pixels per column, using four
// line memories that shift down one line at each accepted column.
module fir_line_buffer
    import fir_line_buffer_pkg::*;
#(
    parameter int IMG_WIDTH = 640
) (
    input  logic              clk,
    input  logic              rst,
    fir_line_buffer_if.slave  bus
);

    localparam int               COL_W     = col_w(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [2:0]       ROWS_FULL = 3'(LINE_BUFS);

    logic [COL_W-1:0] col_cnt;
    logic [2:0]       rows_filled;
    logic [COL_W-1:0] col_eff;
    logic [2:0]       rows_eff;

    logic [PIX_W-1:0] rd_data [LINE_BUFS];
    logic [PIX_W-1:0] wr_data [LINE_BUFS];

    // A start-of-frame beat is column 0 of line 0 regardless of where the
    // counters were, which also discards any partial line.
    always_comb begin
        col_eff  = col_cnt;
        rows_eff = rows_filled;
        if (bus.in_sof) begin
            col_eff  = '0;
            rows_eff = '0;
        end
    end

    for (genvar k = 0; k < LINE_BUFS; k++) begin : g_line
        if (k == LINE_BUFS - 1) begin : g_newest
            assign wr_data[k] = bus.in_pixel;
        end else begin : g_older
            assign wr_data[k] = rd_data[k+1];
        end

        fir_line_buffer_line_ram #(
            .DEPTH (IMG_WIDTH),
            .AW    (COL_W),
            .DW    (PIX_W)
        ) u_ram (
            .clk   (clk),
            .we    (bus.in_valid),
            .addr  (col_eff),
            .wdata (wr_data[k]),
            .rdata (rd_data[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt       <= '0;
            rows_filled   <= '0;
            bus.pixel0    <= '0;
            bus.pixel1    <= '0;
            bus.pixel2    <= '0;
            bus.pixel3    <= '0;
            bus.pixel4    <= '0;
            bus.out_col   <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.pixel0    <= rd_data[0];
            bus.pixel1    <= rd_data[1];
            bus.pixel2    <= rd_data[2];
            bus.pixel3    <= rd_data[3];
            bus.pixel4    <= bus.in_pixel;
            bus.out_col   <= col_eff;
            bus.out_valid <= (rows_eff == ROWS_FULL);
            if (col_eff == COL_LAST) begin
                col_cnt     <= '0;
                rows_filled <= (rows_eff == ROWS_FULL) ? ROWS_FULL : rows_eff + 3'd1;
            end else begin
                col_cnt     <= col_eff + COL_W'(1);
                rows_filled <= rows_eff;
            end
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_line_buffer.sv
// Directed bench for fir_line_buffer with an image-history model and
// literal window checks at frame-fill, wrap, restart and reset points.
module tb_fir_line_buffer;
    import fir_line_buffer_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_line_buffer_if #(.IMG_WIDTH(W)) bus ();

    fir_line_buffer #(.IMG_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;
    int cap_mode = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [7:0] p0, input logic [7:0] p1,
                                         input logic [7:0] p2, input logic [7:0] p3,
                                         input logic [7:0] p4, input int col);
        return {21'b0, p0, p1, p2, p3, p4, 3'(col)};
    endfunction

    function automatic logic [63:0] dut_win();
        return {21'b0, bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4, bus.out_col};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic v, input logic s, input logic [7:0] p);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 8'h00);
    endtask

    task automatic lit(input string name, input logic v, input logic [7:0] p0, input logic [7:0] p1,
                       input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] p4, input int col);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'(v));
        chk({name, "_win"}, dut_win(), pack(p0, p1, p2, p3, p4, col));
    endtask

    // ---------------- image-history model ----------------
    logic [7:0] img [64][W];
    int m_row = 0, m_col = 0, r_cur = 0, c_cur = 0, exp_col = 0;
    logic exp_valid = 1'b0, exp_known = 1'b1;
    logic [7:0] exp_px [5] = '{default: 8'h00};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_row = 0; m_col = 0; exp_col = 0;
            exp_valid = 1'b0; exp_known = 1'b1;
            for (int k = 0; k < 5; k++) exp_px[k] = 8'h00;
        end else if (bus.in_valid) begin
            r_cur = bus.in_sof ? 0 : m_row;
            c_cur = bus.in_sof ? 0 : m_col;
            img[r_cur % 64][c_cur] = bus.in_pixel;
            exp_valid = (r_cur >= 4);
            exp_known = (r_cur >= 4);
            exp_col   = c_cur;
            if (r_cur >= 4)
                for (int k = 0; k < 5; k++) exp_px[k] = img[(r_cur - 4 + k) % 64][c_cur];
            m_col = (c_cur == W - 1) ? 0 : c_cur + 1;
            m_row = (c_cur == W - 1) ? r_cur + 1 : r_cur;
        end else begin
            exp_valid = 1'b0;
        end
    end

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
            if (exp_known)
                chk("window", dut_win(),
                    pack(exp_px[0], exp_px[1], exp_px[2], exp_px[3], exp_px[4], exp_col));
            if (bus.out_valid && cap_mode == 1) exp_q.push_back(dut_win());
            if (bus.out_valid && cap_mode == 2) begin
                if (exp_q.size() == 0) chk("bubble_seq_extra", 64'(1), 64'(0));
                else chk("bubble_seq", dut_win(), exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_state", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        chk_on = 1'b1;
        idle(3);
        lit("post_reset_idle", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Fill and wrap, gap-free; valid windows recorded for the bubble run.
        cap_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < W; c++) begin
                send(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                if (r == 3 && c == 7) chk("fill_r3c7_valid", 64'(bus.out_valid), 64'(0));
                if (r == 4 && c == 0) lit("fill_r4c0", 1'b1, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 0);
                if (r == 4 && c == 7) lit("wrap_r4c7", 1'b1, 8'h07, 8'h17, 8'h27, 8'h37, 8'h47, 7);
                if (r == 5 && c == 0) lit("wrap_r5c0", 1'b1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 0);
                if (r == 5 && c == 3) lit("wrap_r5c3", 1'b1, 8'h13, 8'h23, 8'h33, 8'h43, 8'h53, 3);
            end
        end
        idle(1);
        cap_mode = 0;
        chk("gapfree_windows", 64'(exp_q.size()), 64'(16));

        // Same frame with bubbles during rows 4-5.
        cap_mode = 2;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r >= 4) idle((c == 3) ? 1 : int'($urandom_range(0, 2)));
                send(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
            end
        end
        idle(1);
        cap_mode = 0;
        chk("bubble_seq_len", 64'(exp_q.size()), 64'(0));

        // Row 6 starts, then a new frame begins at column 2.
        send(1'b1, 1'b0, 8'h60);
        send(1'b1, 1'b0, 8'h61);
        for (int i = 0; i < 44; i++) begin
            send(1'b1, (i == 0), 8'h80 | 8'((i / W) * 16 + (i % W)));
            if (i == 31) chk("sof_r3c7_valid", 64'(bus.out_valid), 64'(0));
            if (i == 32) lit("sof_r4c0", 1'b1, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 0);
        end

        // Asynchronous reset mid-line, after new-frame row 5 col 3.
        #2;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        lit("async_reset", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        lit("reset_hold", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        lit("reset_release", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

        // Restart without sof: the first pixel is column 0 of line 0.
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 1'b0, 8'(8'h40 + i));
            if (i == 31) chk("restart_r3c7_valid", 64'(bus.out_valid), 64'(0));
            if (i == 32) lit("restart_r4c0", 1'b1, 8'h40, 8'h48, 8'h50, 8'h58, 8'h60, 0);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
